// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common data bus arbiter for the functional-unit result sources
// (0 ALU, 1 MUL, 2 LOAD, 3 BRANCH). Each cycle it grants one pending source
// combinationally and registers that source's payload for a one-cycle broadcast.
// Build option: define CDB_RR_EN for round-robin arbitration. Without it the
// arbiter uses fixed priority, where the lowest index wins and there is no rr_ptr.
module cdb_arbiter #(
   parameter int NSRC    = 4,
   parameter int XLEN    = 32,
   parameter int PRF_LEN = 6,
   parameter int ROB_LEN = 5
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    squash,
   input  logic [NSRC-1:0]         src_valid,
   input  logic [NSRC*XLEN-1:0]    src_value,
   input  logic [NSRC*PRF_LEN-1:0] src_prf_idx,
   input  logic [NSRC*ROB_LEN-1:0] src_rob_idx,
   input  logic [NSRC*XLEN-1:0]    src_PC,
   output logic [NSRC-1:0]         src_grant,
   output logic                    cdb_valid,
   output logic [XLEN-1:0]         cdb_value,
   output logic [PRF_LEN-1:0]      cdb_prf_idx,
   output logic [ROB_LEN-1:0]      cdb_rob_idx,
   output logic [XLEN-1:0]         cdb_PC,
   output logic [1:0]              cdb_src
);

   logic               grant_any;
   logic [1:0]         grant_idx;
   logic [NSRC-1:0]    grant;

   logic               cdb_valid_d,   cdb_valid_q;
   logic [XLEN-1:0]    cdb_value_d,   cdb_value_q;
   logic [PRF_LEN-1:0] cdb_prf_idx_d, cdb_prf_idx_q;
   logic [ROB_LEN-1:0] cdb_rob_idx_d, cdb_rob_idx_q;
   logic [XLEN-1:0]    cdb_PC_d,      cdb_PC_q;
   logic [1:0]         cdb_src_d,     cdb_src_q;

`ifdef CDB_RR_EN
   logic [1:0]         rr_ptr_d, rr_ptr_q;
`endif

   // Pick the first valid source in search order. Reset and squash suppress all grants.
   always_comb begin
      logic [1:0] idx;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = '0;
      if (!reset && !squash) begin
         for (int unsigned i = 0; i < NSRC; i++) begin
`ifdef CDB_RR_EN
            idx = 2'((int'(rr_ptr_q) + i) % NSRC);
`else
            idx = 2'(i);
`endif
            if (!grant_any && src_valid[idx]) begin
               grant_any      = 1'b1;
               grant_idx      = idx;
               grant[idx]     = 1'b1;
            end
         end
      end
   end

   // Load the next broadcast from the granted source. With no grant, the payload holds its last value.
   always_comb begin
      cdb_valid_d   = grant_any;
      cdb_value_d   = cdb_value_q;
      cdb_prf_idx_d = cdb_prf_idx_q;
      cdb_rob_idx_d = cdb_rob_idx_q;
      cdb_PC_d      = cdb_PC_q;
      cdb_src_d     = cdb_src_q;
      if (grant_any) begin
         cdb_value_d   = src_value[int'(grant_idx)*XLEN +: XLEN];
         cdb_prf_idx_d = src_prf_idx[int'(grant_idx)*PRF_LEN +: PRF_LEN];
         cdb_rob_idx_d = src_rob_idx[int'(grant_idx)*ROB_LEN +: ROB_LEN];
         cdb_PC_d      = src_PC[int'(grant_idx)*XLEN +: XLEN];
         cdb_src_d     = grant_idx;
      end
   end

`ifdef CDB_RR_EN
   // After a grant, move the round-robin pointer to the source just past the winner.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_any) begin
         rr_ptr_d = (int'(grant_idx) == NSRC - 1) ? 2'd0 : grant_idx + 2'd1;
      end
   end

   // Round-robin pointer register, cleared by synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) rr_ptr_q <= '0;
      else       rr_ptr_q <= rr_ptr_d;
   end
`endif

   // Broadcast registers, cleared by synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         cdb_valid_q   <= 1'b0;
         cdb_value_q   <= '0;
         cdb_prf_idx_q <= '0;
         cdb_rob_idx_q <= '0;
         cdb_PC_q      <= '0;
         cdb_src_q     <= '0;
      end else begin
         cdb_valid_q   <= cdb_valid_d;
         cdb_value_q   <= cdb_value_d;
         cdb_prf_idx_q <= cdb_prf_idx_d;
         cdb_rob_idx_q <= cdb_rob_idx_d;
         cdb_PC_q      <= cdb_PC_d;
         cdb_src_q     <= cdb_src_d;
      end
   end

   assign src_grant   = grant;
   assign cdb_valid   = cdb_valid_q;
   assign cdb_value   = cdb_value_q;
   assign cdb_prf_idx = cdb_prf_idx_q;
   assign cdb_rob_idx = cdb_rob_idx_q;
   assign cdb_PC      = cdb_PC_q;
   assign cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized checks of cdb_arbiter against a
// behavioural model. The model follows the CDB_RR_EN setting of the build.
module tb_cdb_arbiter;
   localparam int NSRC    = 4;
   localparam int XLEN    = 32;
   localparam int PRF_LEN = 6;
   localparam int ROB_LEN = 5;

   logic                    clock = 1'b0;
   logic                    reset = 1'b1;
   logic                    squash = 1'b0;
   logic [NSRC-1:0]         src_valid = '0;
   logic [NSRC*XLEN-1:0]    src_value = '0;
   logic [NSRC*PRF_LEN-1:0] src_prf_idx = '0;
   logic [NSRC*ROB_LEN-1:0] src_rob_idx = '0;
   logic [NSRC*XLEN-1:0]    src_PC = '0;
   logic [NSRC-1:0]         src_grant;
   logic                    cdb_valid;
   logic [XLEN-1:0]         cdb_value;
   logic [PRF_LEN-1:0]      cdb_prf_idx;
   logic [ROB_LEN-1:0]      cdb_rob_idx;
   logic [XLEN-1:0]         cdb_PC;
   logic [1:0]              cdb_src;

   always #5 clock = ~clock;

   cdb_arbiter #(.NSRC(NSRC), .XLEN(XLEN), .PRF_LEN(PRF_LEN), .ROB_LEN(ROB_LEN)) dut (
      .clock(clock), .reset(reset), .squash(squash),
      .src_valid(src_valid), .src_value(src_value), .src_prf_idx(src_prf_idx),
      .src_rob_idx(src_rob_idx), .src_PC(src_PC), .src_grant(src_grant),
      .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_prf_idx(cdb_prf_idx),
      .cdb_rob_idx(cdb_rob_idx), .cdb_PC(cdb_PC), .cdb_src(cdb_src)
   );

   int checks = 0;
   int errors = 0;

   // Payload offered by each source in the current cycle.
   logic [XLEN-1:0]    t_val[NSRC];
   logic [XLEN-1:0]    t_pc[NSRC];
   logic [PRF_LEN-1:0] t_prf[NSRC];
   logic [ROB_LEN-1:0] t_rob[NSRC];

   // Reference model state.
   int                 m_ptr = 0;
   logic               m_valid = 1'b0;
   logic [XLEN-1:0]    m_value = '0;
   logic [XLEN-1:0]    m_pc = '0;
   logic [PRF_LEN-1:0] m_prf = '0;
   logic [ROB_LEN-1:0] m_rob = '0;
   logic [1:0]         m_src = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Return the first valid source found by scanning upward from ptr modulo NSRC, or -1 if none is valid.
   function automatic int pick(input logic [NSRC-1:0] v, input int ptr);
      for (int n = 0; n < NSRC; n++) begin
         int k;
         k = (ptr + n) % NSRC;
         if (v[k]) return k;
      end
      return -1;
   endfunction

   task automatic rand_payload();
      for (int i = 0; i < NSRC; i++) begin
         t_val[i] = $urandom;
         t_pc[i]  = $urandom;
         t_prf[i] = PRF_LEN'($urandom);
         t_rob[i] = ROB_LEN'($urandom);
      end
   endtask

   // Run one clock cycle: drive the inputs, check the grant mid-cycle,
   // step the model at the edge, then check the broadcast outputs.
   task automatic cycle(input logic [NSRC-1:0] v, input logic sq, input logic rst, input string tag);
      int k;
      logic [NSRC-1:0] one;
      logic [NSRC-1:0] exp_g;
      one = 1;
      reset = rst;
      squash = sq;
      src_valid = v;
      for (int i = 0; i < NSRC; i++) begin
         src_value[i*XLEN +: XLEN]          = t_val[i];
         src_PC[i*XLEN +: XLEN]             = t_pc[i];
         src_prf_idx[i*PRF_LEN +: PRF_LEN]  = t_prf[i];
         src_rob_idx[i*ROB_LEN +: ROB_LEN]  = t_rob[i];
      end
      k = (rst || sq) ? -1 : pick(v, m_ptr);
      exp_g = (k < 0) ? '0 : (one << k);
      #4;
      chk({tag, "_grant"}, 64'(src_grant), 64'(exp_g));
      @(posedge clock);
      if (rst) begin
         m_ptr = 0; m_valid = 1'b0; m_value = '0; m_pc = '0;
         m_prf = '0; m_rob = '0; m_src = '0;
      end else if (k >= 0) begin
         m_valid = 1'b1;
         m_value = t_val[k];
         m_pc    = t_pc[k];
         m_prf   = t_prf[k];
         m_rob   = t_rob[k];
         m_src   = 2'(k);
`ifdef CDB_RR_EN
         m_ptr   = (k + 1) % NSRC;
`endif
      end else begin
         m_valid = 1'b0;
      end
      #1;
      chk({tag, "_valid"}, 64'(cdb_valid), 64'(m_valid));
      chk({tag, "_value"}, 64'(cdb_value), 64'(m_value));
      chk({tag, "_prf"},   64'(cdb_prf_idx), 64'(m_prf));
      chk({tag, "_rob"},   64'(cdb_rob_idx), 64'(m_rob));
      chk({tag, "_pc"},    64'(cdb_PC), 64'(m_pc));
      chk({tag, "_src"},   64'(cdb_src), 64'(m_src));
   endtask

   initial begin
      rand_payload();
      // Reset and its zeroed state.
      cycle(4'b1111, 1'b0, 1'b1, "rst0");
      cycle(4'b0000, 1'b0, 1'b1, "rst1");

      // A single MUL result.
      rand_payload();
      t_val[1] = 32'h0000_0006; t_prf[1] = 6'd5; t_rob[1] = 5'd3;
      cycle(4'b0010, 1'b0, 1'b0, "mul");
      chk("mul_lit_value", 64'(cdb_value), 64'd6);
      chk("mul_lit_prf", 64'(cdb_prf_idx), 64'd5);
      chk("mul_lit_rob", 64'(cdb_rob_idx), 64'd3);
      chk("mul_lit_src", 64'(cdb_src), 64'd1);
      cycle(4'b0000, 1'b0, 1'b0, "idle");

      // All sources valid for four cycles after a fresh reset.
      cycle(4'b0000, 1'b0, 1'b1, "rst2");
      for (int c = 0; c < 4; c++) begin
         rand_payload();
         cycle(4'b1111, 1'b0, 1'b0, "all");
      end

      // Squash suppresses the grant; arbitration resumes in the next cycle.
      rand_payload();
      cycle(4'b0110, 1'b1, 1'b0, "sq");
      cycle(4'b0110, 1'b0, 1'b0, "sq_resume");
      cycle(4'b0110, 1'b1, 1'b0, "sq_keep");

      // Grant LOAD so rr_ptr reaches 3, then check the wrap to ALU.
      cycle(4'b0000, 1'b0, 1'b1, "rst3");
      rand_payload();
      cycle(4'b0100, 1'b0, 1'b0, "wrap_a");
      cycle(4'b0001, 1'b0, 1'b0, "wrap_b");
      cycle(4'b0011, 1'b0, 1'b0, "wrap_c");

      // Reset in the cycle after a grant.
      rand_payload();
      cycle(4'b1000, 1'b0, 1'b0, "rmid_g");
      cycle(4'b1111, 1'b0, 1'b1, "rmid_r");

      // Randomized traffic with occasional squash and reset.
      for (int c = 0; c < 400; c++) begin
         rand_payload();
         cycle(NSRC'($urandom_range(0, 15)),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 39) == 0), "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: NSRC, 4, number of functional-unit result sources (index 0 ALU, 1 MUL, 2 LOAD, 3 BRANCH).
REQ-002 Parameter: XLEN, 32, result value / PC width.
REQ-003 Parameter: PRF_LEN, 6, physical register index width.
REQ-004 Parameter: ROB_LEN, 5, ROB index width.
REQ-005 Clock and reset: clock is the clock; reset is synchronous, active-high.
REQ-006 Port: clock  in  1  rising-edge clock.
REQ-007 Port: reset  in  1  synchronous active-high reset.
REQ-008 Port: squash  in  1  pipeline flush; kills pending broadcast.
REQ-009 Port: src_valid  in  NSRC  per-source result pending; held high until granted.
REQ-010 Port: src_value  in  NSRC*XLEN  per-source result value.
REQ-011 Port: src_prf_idx  in  NSRC*PRF_LEN  per-source destination preg.
REQ-012 Port: src_rob_idx  in  NSRC*ROB_LEN  per-source ROB entry.
REQ-013 Port: src_PC  in  NSRC*XLEN  per-source instruction PC.
REQ-014 Port: src_grant  out  NSRC  one-hot grant; bit 1 is the MUL unit's cdb_broadcast_is_mul.
REQ-015 Port: cdb_valid  out  1  broadcast valid.
REQ-016 Port: cdb_value / cdb_prf_idx / cdb_rob_idx / cdb_PC  out  XLEN / PRF_LEN / ROB_LEN / XLEN  broadcast payload.
REQ-017 Port: cdb_src  out  2  index of the source that produced the current broadcast.

Function
REQ-018 src_grant SHALL be combinational from src_valid and the priority state, at most one bit set, zero when src_valid==0 or squash==1.
REQ-019 A grant in cycle N SHALL register the granted payload so cdb_valid and payload appear in cycle N+1 (latency 1), held exactly one cycle.
REQ-020 cdb_valid SHALL be 0 in any cycle following a cycle with no grant; payload outputs are don't-care then but SHALL hold their last value.
REQ-021 Throughput SHALL be one broadcast per cycle; back-to-back grants to different or the same source are legal.
REQ-022 A source SHALL drop src_valid the cycle after its grant unless it has a new result; the arbiter SHALL NOT rely on this and SHALL re-grant a still-valid source per priority.
REQ-023 Priority state: rr_ptr (2 bits); search order rr_ptr, rr_ptr+1, ... modulo NSRC, wrapping 3->0.
REQ-024 On a grant to source k, rr_ptr SHALL update to (k+1) mod NSRC at the clock edge; with no grant rr_ptr SHALL hold.
REQ-025 squash in cycle N SHALL force src_grant=0 in N and cdb_valid=0 in N+1; rr_ptr SHALL hold.
REQ-026 squash in the same cycle as a registered broadcast (cdb_valid=1) SHALL NOT retract it; the current broadcast completes.
REQ-027 Starvation bound: any continuously valid source SHALL be granted within NSRC cycles (round-robin build).

Reset
REQ-028 While reset is high: src_grant=0, cdb_valid=0, cdb_value/cdb_PC=0, cdb_prf_idx=0, cdb_rob_idx=0, cdb_src=0, rr_ptr=0.
REQ-029 Reset asserted mid-operation SHALL discard any registered broadcast at the next edge; first grant possible in the cycle reset deasserts.

Configuration
REQ-030 Macro CDB_RR_EN defined: round-robin arbitration per REQ-023/024/027.
REQ-031 CDB_RR_EN undefined: fixed priority, lowest index wins (ALU > MUL > LOAD > BRANCH), rr_ptr absent, REQ-027 waived; all other requirements unchanged.

Verification
REQ-032 Reset then src_valid=4'b0010, MUL value 0x0000_0006, prf 5, rob 3 -> src_grant=4'b0010 same cycle; next cycle cdb_valid=1, cdb_value=6, cdb_prf_idx=5, cdb_rob_idx=3, cdb_src=1.
REQ-033 src_valid=4'b1111 held 4 cycles, RR build -> grants 0001,0010,0100,1000 in order; cdb_src 0,1,2,3 one cycle later.
REQ-034 Same stimulus, fixed-priority build -> grant 0001 every cycle; cdb_src=0 each cycle.
REQ-035 src_valid=4'b0110 with squash=1 in cycle N -> src_grant=0 in N, cdb_valid=0 in N+1, rr_ptr unchanged; grant resumes in N+1.
REQ-036 rr_ptr=3 (after BRANCH grant... set by granting source 2), src_valid=4'b0001 -> wrap-around: grant 0001, rr_ptr becomes 1.
REQ-037 Reset asserted the cycle after a grant -> cdb_valid=0 in the following cycle, all outputs zero.
